// File: rtl/serial_mag_ctrl.sv
// Bit-serial word comparator sequencer driving an external 1-bit magnitude comparator, MSB first.
// Build option MAG_EARLY_EXIT_EN: finish on the first differing bit instead of always scanning all WIDTH bits.
module serial_mag_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_equal,
  input  logic             bit_greater,
  input  logic             bit_lower,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             lower,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic           decided, dec_gt;

  logic resp_ok, dec_now, gt_now, stop_now;

  // The sticky decision folds in the current bit only until the first difference is seen.
  always_comb begin
    resp_ok = ({bit_equal, bit_greater, bit_lower} == 3'b100) ||
              ({bit_equal, bit_greater, bit_lower} == 3'b010) ||
              ({bit_equal, bit_greater, bit_lower} == 3'b001);
    dec_now = decided | ~bit_equal;
    gt_now  = decided ? dec_gt : bit_greater;
`ifdef MAG_EARLY_EXIT_EN
    stop_now = (idx == '0) | dec_now;
`else
    stop_now = (idx == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      bit_a   <= 1'b0;
      bit_b   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
      lower   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // MSB goes straight onto the comparator; the shifters hold the remaining bits.
            bit_a   <= a_in[WIDTH-1];
            bit_b   <= b_in[WIDTH-1];
            sh_a    <= a_in << 1;
            sh_b    <= b_in << 1;
            idx     <= IW'(WIDTH - 1);
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            lower   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= CMP;
          end
        end
        CMP: begin
          if (!resp_ok) begin
            err     <= 1'b1;
            equal   <= 1'b0;
            greater <= 1'b0;
            lower   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (stop_now) begin
            equal   <= ~dec_now;
            greater <= dec_now & gt_now;
            lower   <= dec_now & ~gt_now;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            decided <= dec_now;
            dec_gt  <= gt_now;
            idx     <= idx - IW'(1);
            bit_a   <= sh_a[WIDTH-1];
            bit_b   <= sh_b[WIDTH-1];
            sh_a    <= sh_a << 1;
            sh_b    <= sh_b << 1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_ctrl.sv
// Directed bench for serial_mag_ctrl with a behavioural 1-bit comparator and a result scoreboard.
module tb_serial_mag_ctrl;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] a_in, b_in;
  logic         bit_a, bit_b, bit_equal, bit_greater, bit_lower;
  logic         busy, done, equal, greater, lower, err;
  logic         inj;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] a, b;
    logic eq, gt, lt, er;
    int   due;
  } exp_t;

  exp_t sbq[$];

  serial_mag_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .bit_a(bit_a), .bit_b(bit_b), .bit_equal(bit_equal), .bit_greater(bit_greater),
    .bit_lower(bit_lower), .busy(busy), .done(done), .equal(equal),
    .greater(greater), .lower(lower), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model; inj forces a non-one-hot response.
  always_comb begin
    bit_equal   = inj | (bit_a == bit_b);
    bit_greater = inj | (bit_a & ~bit_b);
    bit_lower   = ~bit_a & bit_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result; due holds the latency in cycles (done seen n cycles after accept).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   found;
    e.a = a; e.b = b; e.er = 1'b0;
    e.eq = 1'b1; e.gt = 1'b0; e.lt = 1'b0; e.due = W + 1;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && a[i] != b[i]) begin
        found = 1'b1;
        e.eq = 1'b0; e.gt = a[i]; e.lt = ~a[i];
`ifdef MAG_EARLY_EXIT_EN
        e.due = W - i + 1;
`endif
      end
    end
    return e;
  endfunction

  task automatic check_done();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("spurious_done", 32'(done), 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("equal",   32'(equal),   32'(e.eq));
      chk("greater", 32'(greater), 32'(e.gt));
      chk("lower",   32'(lower),   32'(e.lt));
      chk("err",     32'(err),     32'(e.er));
      chk("done_cycle", 32'(cyc),  32'(e.due));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, 32'({bit_a, bit_b, busy, done, equal, greater, lower, err}), 32'd0);
  endtask

  // One compare; inj_bit >= 0 corrupts the comparator response for that bit position.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int inj_bit);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    for (int n = 1; n <= W + 4 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        if (inj_bit >= 0) begin
          e.a = a; e.b = b; e.eq = 1'b0; e.gt = 1'b0; e.lt = 1'b0; e.er = 1'b1;
          e.due = W - inj_bit + 1;
        end else begin
          e = model(a, b);
        end
        e.due = cyc + e.due - 1;
        sbq.push_back(e);
      end
      inj = (inj_bit >= 0) && (n == W - inj_bit);
      if (done) begin
        check_done();
        got = 1'b1;
      end else if (n <= W) begin
        chk("busy", 32'(busy), 32'd1);
        chk("bit_pair", 32'({bit_a, bit_b}), 32'({a[W-n], b[W-n]}));
      end
    end
    inj = 1'b0;
    if (!got) chk("done_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    exp_t e1, e2;
    int   ndone;
    bit   fin;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; inj = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_cmp(8'hA5, 8'hA5, -1);
    run_cmp(8'h80, 8'h7F, -1);
    run_cmp(8'h10, 8'h11, -1);
    run_cmp(8'h00, 8'hFF, -1);
    run_cmp(8'h55, 8'h55, 5);

    // start held high across two compares; a_in changes during the first.
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h3D; start = 1'b1;
    ndone = 0;
    fin = 1'b0;
    for (int n = 1; n <= 3 * W + 8 && !fin; n++) begin
      @(negedge clk);
      if (n == 1) begin
        e1 = model(8'h3C, 8'h3D);
        e1.due = cyc + e1.due - 1;
        e2 = model(8'h3E, 8'h3D);
        e2.due = cyc + (W + 2) + e2.due - 1;
        sbq.push_back(e1);
        sbq.push_back(e2);
      end
      if (n == 3) a_in = 8'h3E;
      if (n == W + 3) start = 1'b0;
      if (done) begin
        check_done();
        ndone++;
        if (ndone == 2) fin = 1'b1;
      end
    end
    chk("held_start_dones", 32'(ndone), 32'd2);
    start = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) check_done();
    end
    sbq.delete();

    // Reset asserted mid-compare aborts with no done pulse.
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_abort");
    run_cmp(8'hF0, 8'h0F, -1);

    repeat (W + 4) begin
      @(negedge clk);
      if (done) check_done();
    end
    chk("queue_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
